// File: rtl/systolic_matmul_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// systolic_matmul_engine -- NxN output-stationary systolic C = A x B, rev 1.0
// ----------------------------------------------------------------------------
module systolic_matmul_engine #(
   parameter int N          = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int K_MAX      = 255,
   parameter bit SIGNED     = 1'b1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic                           start,
   input  logic [$clog2(K_MAX+1)-1:0]     k_len,
   output logic                           busy,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [N*DATA_WIDTH-1:0]        in_a,
   input  logic [N*DATA_WIDTH-1:0]        in_b,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [N*N*ACC_WIDTH-1:0]       out_c
);
   localparam int KW = $clog2(K_MAX+1);
   localparam int FW = $clog2(2*N-1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                     state_q, state_d;
   logic [KW-1:0]              k_q, k_d, beat_q, beat_d;
   logic [FW-1:0]              flush_q, flush_d;
   logic                       out_valid_q, out_valid_d;
   logic [N*N*ACC_WIDTH-1:0]   out_c_q, out_c_d;
   logic [N*N*ACC_WIDTH-1:0]   acc_flat;
   logic                       clr_acc, accept;
   logic [N*DATA_WIDTH-1:0]    inj_a, inj_b;
   logic [N-1:0][DATA_WIDTH-1:0]        a_row, b_col;
   logic [N-1:0][N-1:0][DATA_WIDTH-1:0] a_in, b_in;

   function automatic logic [ACC_WIDTH-1:0] ext(input logic [DATA_WIDTH-1:0] v);
      return {{(ACC_WIDTH-DATA_WIDTH){v[DATA_WIDTH-1] & SIGNED}}, v};
   endfunction

   assign accept    = (state_q == S_LOAD) && in_valid;
   // Anything not an accepted beat enters the array as zero, so A and B stall together.
   assign inj_a     = accept ? in_a : '0;
   assign inj_b     = accept ? in_b : '0;
   assign busy      = (state_q != S_IDLE);
   assign in_ready  = (state_q == S_LOAD);
   assign out_valid = out_valid_q;
   assign out_c     = out_c_q;

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      beat_d      = beat_q;
      flush_d     = flush_q;
      out_valid_d = out_valid_q;
      out_c_d     = out_c_q;
      clr_acc     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               k_d     = k_len;
               beat_d  = '0;
               flush_d = '0;
               clr_acc = 1'b1;
               state_d = (k_len == '0) ? S_FLUSH : S_LOAD;
            end
         end
         S_LOAD: begin
            if (in_valid) begin
               if (beat_q == k_q - KW'(1)) begin
                  state_d = S_FLUSH;
                  flush_d = '0;
               end else begin
                  beat_d = beat_q + KW'(1);
               end
            end
         end
         S_FLUSH: begin
            // The last beat reaches cell (N-1,N-1) 2N-2 edges later; sample on the next one.
            if (flush_q == FW'(2*N-2)) begin
               state_d     = S_DONE;
               out_c_d     = acc_flat;
               out_valid_d = 1'b1;
            end else begin
               flush_d = flush_q + FW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         beat_q      <= '0;
         flush_q     <= '0;
         out_valid_q <= 1'b0;
         out_c_q     <= '0;
      end else if (en) begin
         state_q     <= state_d;
         k_q         <= k_d;
         beat_q      <= beat_d;
         flush_q     <= flush_d;
         out_valid_q <= out_valid_d;
         out_c_q     <= out_c_d;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_skew
      if (i == 0) begin : g_direct
         assign a_row[i] = inj_a[i*DATA_WIDTH +: DATA_WIDTH];
         assign b_col[i] = inj_b[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_delay
         logic [i-1:0][DATA_WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
         always_comb begin
            sa_d[0] = inj_a[i*DATA_WIDTH +: DATA_WIDTH];
            sb_d[0] = inj_b[i*DATA_WIDTH +: DATA_WIDTH];
            for (int d = 1; d < i; d++) begin
               sa_d[d] = sa_q[d-1];
               sb_d[d] = sb_q[d-1];
            end
         end
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               sa_q <= '0;
               sb_q <= '0;
            end else if (en) begin
               sa_q <= sa_d;
               sb_q <= sb_d;
            end
         end
         assign a_row[i] = sa_q[i-1];
         assign b_col[i] = sb_q[i-1];
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic [ACC_WIDTH-1:0] acc_q, acc_d, prod;
         assign prod  = ext(a_in[i][j]) * ext(b_in[i][j]);
         assign acc_d = clr_acc ? '0 : acc_q + prod;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)    acc_q <= '0;
            else if (en) acc_q <= acc_d;
         end
         assign acc_flat[(i*N+j)*ACC_WIDTH +: ACC_WIDTH] = acc_q;

         if (j == 0) begin : g_a_edge
            assign a_in[i][j] = a_row[i];
         end
         if (i == 0) begin : g_b_edge
            assign b_in[i][j] = b_col[j];
         end
         if (j < N-1) begin : g_a_pass
            logic [DATA_WIDTH-1:0] a_q, a_d;
            assign a_d = a_in[i][j];
            always_ff @(posedge clk or negedge rst) begin
               if (!rst)    a_q <= '0;
               else if (en) a_q <= a_d;
            end
            assign a_in[i][j+1] = a_q;
         end
         if (i < N-1) begin : g_b_pass
            logic [DATA_WIDTH-1:0] b_q, b_d;
            assign b_d = b_in[i][j];
            always_ff @(posedge clk or negedge rst) begin
               if (!rst)    b_q <= '0;
               else if (en) b_q <= b_d;
            end
            assign b_in[i+1][j] = b_q;
         end
      end
   end

   if (K_MAX < (1 << KW) - 1) begin : g_k_check
      assert property (@(posedge clk) disable iff (!rst)
         (en && start && state_q == S_IDLE) |-> (k_len <= KW'(K_MAX)));
   end

endmodule
`default_nettype wire

// File: tb/tb_systolic_matmul_engine.sv
`default_nettype none
// tb_systolic_matmul_engine: directed and randomised jobs on signed and unsigned
// instances, checked against a plain-arithmetic matrix product model.
module tb_systolic_matmul_engine;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int AW = 32;
   localparam int KW = 8;
   localparam int KS = 16;

   logic clk = 1'b0, rst = 1'b0, en = 1'b1, start = 1'b0;
   logic in_valid = 1'b0, out_ready = 1'b0;
   logic [KW-1:0]     k_len = '0;
   logic [N*DW-1:0]   in_a = '0, in_b = '0;
   logic              busy, in_ready, out_valid, busy_u, in_ready_u, out_valid_u;
   logic [N*N*AW-1:0] out_c, out_c_u;

   logic [DW-1:0] ma [N][KS];
   logic [DW-1:0] mb [KS][N];
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   systolic_matmul_engine #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(255), .SIGNED(1'b1)) u_dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .k_len(k_len), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c));

   systolic_matmul_engine #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(255), .SIGNED(1'b0)) u_dut_u (
      .clk(clk), .rst(rst), .en(en), .start(start), .k_len(k_len), .busy(busy_u),
      .in_valid(in_valid), .in_ready(in_ready_u), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid_u), .out_ready(out_ready), .out_c(out_c_u));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW-1:0] ref_c(input int i, input int j, input int K, input bit sgn);
      longint s = 0;
      for (int k = 0; k < K; k++) begin
         if (sgn) s += longint'($signed(ma[i][k])) * longint'($signed(mb[k][j]));
         else     s += longint'(ma[i][k]) * longint'(mb[k][j]);
      end
      return s[AW-1:0];
   endfunction

   // mode 0: A=I, B[k][j]=4k+j; 1: all 0x80; 2: all 0xFF; 3: all 1; else random
   task automatic fill(input int mode);
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < KS; k++) begin
            case (mode)
               0: begin ma[i][k] = (i == k) ? 8'd1 : 8'd0; mb[k][i] = 8'(4*k + i); end
               1: begin ma[i][k] = 8'h80; mb[k][i] = 8'h80; end
               2: begin ma[i][k] = 8'hFF; mb[k][i] = 8'hFF; end
               3: begin ma[i][k] = 8'h01; mb[k][i] = 8'h01; end
               default: begin ma[i][k] = 8'($urandom); mb[k][i] = 8'($urandom); end
            endcase
         end
      end
   endtask

   task automatic drive_beat(input int b);
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
         in_a[i*DW +: DW] = ma[i][b];
         in_b[i*DW +: DW] = mb[b][i];
      end
   endtask

   task automatic check_result(input string tag, input int K);
      for (int e = 0; e < N*N; e++) begin
         chk($sformatf("%s_s%0d", tag, e), out_c[e*AW +: AW],   ref_c(e/N, e%N, K, 1'b1));
         chk($sformatf("%s_u%0d", tag, e), out_c_u[e*AW +: AW], ref_c(e/N, e%N, K, 1'b0));
      end
   endtask

   // Runs one job from start up to out_valid; gaps bit b inserts one idle cycle before beat b,
   // en_hold freezes the engine for that many cycles once FLUSH is under way.
   task automatic run_job(input int K, input int gaps, input int en_hold, input string tag);
      int lat, b, since, held;
      bit gap_taken, acc;
      lat = 0; b = 0; since = 0; held = 0; gap_taken = 1'b0;
      start = 1'b1; k_len = KW'(K); in_valid = 1'b0; en = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_busy"}, busy, 1'b1);
      while (!out_valid && lat < 200) begin
         acc = 1'b0;
         en = !(b == K && en_hold > 0 && since >= 2 && held < en_hold);
         in_a = N*DW'($urandom);
         in_b = N*DW'($urandom);
         if (in_ready) begin
            if (gaps[b] && !gap_taken) begin
               in_valid = 1'b0;
               gap_taken = 1'b1;
            end else begin
               drive_beat(b);
               acc = en;
            end
         end else begin
            in_valid = 1'($urandom);
         end
         @(posedge clk); #1;
         lat++;
         if (!en) held++;
         if (acc) begin
            b++; gap_taken = 1'b0; since = 0;
         end else if (en) begin
            since++;
         end
      end
      en = 1'b1; in_valid = 1'b0;
      chk({tag, "_latency"}, lat, K + 2*N - 1 + $countones(gaps) + en_hold);
      chk({tag, "_valid_u"}, out_valid_u, 1'b1);
      check_result(tag, K);
   endtask

   task automatic accept(input string tag, input int K);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_busy0"}, busy, 1'b0);
      chk({tag, "_ovalid0"}, out_valid, 1'b0);
      chk({tag, "_ovalid0_u"}, out_valid_u, 1'b0);
      chk({tag, "_keep"}, out_c[AW-1:0], ref_c(0, 0, K, 1'b1));
   endtask

   initial begin
      int sk, kr, gr, hr;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_c", out_c[63:0], 64'd0);
      chk("rst_out_c_u", out_c_u[63:0], 64'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      fill(0);
      run_job(4, 0, 0, "ident");
      for (int e = 0; e < N*N; e++) chk($sformatf("ident_eqB%0d", e), out_c[e*AW +: AW], e);
      accept("ident", 4);

      // out_ready without a pending result does nothing
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("idle_ready_busy", busy, 1'b0);

      fill(1);
      run_job(4, 0, 0, "neg128");
      chk("neg128_const", out_c[AW-1:0], 32'd65536);
      accept("neg128", 4);

      fill(2);
      run_job(4, 0, 0, "ff");
      chk("ff_unsigned_const", out_c_u[AW-1:0], 32'd260100);
      accept("ff", 4);

      fill(0);
      sk = $urandom_range(0, 3);
      run_job(4, 4'hF & ~(1 << sk), 0, "gaps");
      accept("gaps", 4);

      fill(4);
      run_job(4, 0, 0, "stall");
      for (int c = 0; c < 10; c++) begin
         start = (c == 3);
         k_len = 8'd5;
         @(posedge clk); #1;
         start = 1'b0;
         chk($sformatf("stall_valid%0d", c), out_valid, 1'b1);
         chk($sformatf("stall_in_ready%0d", c), in_ready, 1'b0);
         chk($sformatf("stall_busy%0d", c), busy, 1'b1);
         chk($sformatf("stall_c15_%0d", c), out_c[15*AW +: AW], ref_c(3, 3, 4, 1'b1));
      end
      check_result("stall_hold", 4);
      accept("stall", 4);

      fill(4);
      start = 1'b1; k_len = 8'd4;
      @(posedge clk); #1;
      start = 1'b0;
      for (int b = 0; b < 2; b++) begin
         drive_beat(b);
         @(posedge clk); #1;
      end
      drive_beat(2);
      #2 rst = 1'b0;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_in_ready", in_ready, 1'b0);
      chk("abort_out_valid", out_valid, 1'b0);
      chk("abort_out_c", out_c[63:0], 64'd0);
      @(posedge clk); #1;
      chk("abort_busy_hold", busy | busy_u | in_ready_u, 1'b0);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      fill(3);
      run_job(3, 0, 0, "after_rst");
      chk("after_rst_const", out_c[5*AW +: AW], 32'd3);
      accept("after_rst", 3);

      fill(4);
      run_job(4, 0, 5, "en_hold");
      accept("en_hold", 4);

      run_job(0, 0, 0, "k0");
      chk("k0_zero", out_c[63:0], 64'd0);
      accept("k0", 0);

      for (int r = 0; r < 4; r++) begin
         kr = $urandom_range(1, 12);
         gr = int'($urandom) & ((1 << kr) - 1);
         hr = $urandom_range(0, 3);
         fill(4);
         run_job(kr, gr, hr, $sformatf("rand%0d", r));
         accept($sformatf("rand%0d", r), kr);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
